// File: rtl/aurora_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aurora_pkg : shared datapath width, load-size and WB state encodings |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aurora_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        LS_BYTE  = 2'd0,
        LS_HALF  = 2'd1,
        LS_WORD  = 2'd2,
        LS_DWORD = 2'd3
    } load_size_e;

    typedef enum logic [0:0] {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    // A load is misaligned when its offset is not a multiple of its size.
    function automatic logic is_misaligned(input load_size_e sz, input logic [2:0] off);
        logic mis;
        case (sz)
            LS_BYTE:  mis = 1'b0;
            LS_HALF:  mis = off[0];
            LS_WORD:  mis = |off[1:0];
            default:  mis = |off;
        endcase
        return mis;
    endfunction

endpackage : aurora_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_align : extract and sign/zero-extend a load from a doubleword   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module load_align
    import aurora_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  load_size_e      size_i,
    input  logic            unsigned_i,
    input  logic [2:0]      off_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    always_comb begin
        w_shifted = data_i >> {off_i, 3'b000};
        w_sign    = 1'b0;
        data_o    = w_shifted;
        case (size_i)
            LS_BYTE: begin
                w_sign = ~unsigned_i & w_shifted[7];
                data_o = {{(XLEN-8){w_sign}}, w_shifted[7:0]};
            end
            LS_HALF: begin
                w_sign = ~unsigned_i & w_shifted[15];
                data_o = {{(XLEN-16){w_sign}}, w_shifted[15:0]};
            end
            LS_WORD: begin
                w_sign = ~unsigned_i & w_shifted[31];
                data_o = {{(XLEN-32){w_sign}}, w_shifted[31:0]};
            end
            default: data_o = w_shifted;
        endcase
    end

    assign misalign_o = is_misaligned(size_i, off_i);

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_stage : one-entry write-back stage with load alignment            |
// | Optional WB_INSTRET_EN adds the retired-instruction counter instret_o|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic            mem_rd_we_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic            mem_is_load_i,
    input  logic [1:0]      mem_load_size_i,
    input  logic            mem_load_unsigned_i,
    input  logic [2:0]      mem_byte_off_i,
    input  logic [XLEN-1:0] mem_alu_result_i,
    input  logic [XLEN-1:0] mem_load_data_i,
    input  logic            hold_i,
    output logic            rf_write_en_o,
    output logic [4:0]      rf_write_addr_o,
    output logic [XLEN-1:0] rf_write_data_o,
    output logic            misalign_o
`ifdef WB_INSTRET_EN
    ,
    output logic [XLEN-1:0] instret_o
`endif
);

    import aurora_pkg::*;

    localparam logic [4:0] c_X0 = 5'd0;

    wb_state_e       r_state;
    logic            r_we;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_data;
    logic            r_misalign;

    logic            w_full;
    logic            w_accept;
    logic            w_retire;
    logic [XLEN-1:0] w_load_data;
    logic            w_load_mis;
    logic [XLEN-1:0] w_capture_data;
    logic            w_capture_mis;

    load_align u_load_align (
        .data_i     (mem_load_data_i),
        .size_i     (load_size_e'(mem_load_size_i)),
        .unsigned_i (mem_load_unsigned_i),
        .off_i      (mem_byte_off_i),
        .data_o     (w_load_data),
        .misalign_o (w_load_mis)
    );

    assign w_full      = (r_state == WB_FULL);
    assign mem_ready_o = ~w_full | ~hold_i;
    assign w_accept    = mem_valid_i & mem_ready_o;
    assign w_retire    = w_full & ~hold_i;

    // Size/offset only matter for loads; ALU results pass straight through.
    assign w_capture_data = mem_is_load_i ? w_load_data : mem_alu_result_i;
    assign w_capture_mis  = mem_is_load_i & w_load_mis;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= WB_EMPTY;
            r_we       <= 1'b0;
            r_rd       <= 5'd0;
            r_data     <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                WB_EMPTY: begin
                    if (w_accept) begin
                        r_state <= WB_FULL;
                    end
                end
                WB_FULL: begin
                    if (w_retire && !w_accept) begin
                        r_state <= WB_EMPTY;
                    end
                end
                default: r_state <= WB_EMPTY;
            endcase
            // Retire and accept together simply overwrite the entry.
            if (w_accept) begin
                r_we       <= mem_rd_we_i;
                r_rd       <= mem_rd_addr_i;
                r_data     <= w_capture_data;
                r_misalign <= w_capture_mis;
            end
        end
    end

    assign rf_write_en_o   = w_retire & r_we & ~r_misalign & (r_rd != c_X0);
    assign rf_write_addr_o = r_rd;
    assign rf_write_data_o = r_data;
    assign misalign_o      = w_retire & r_misalign;

`ifdef WB_INSTRET_EN
    logic [XLEN-1:0] r_instret;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instret_o = r_instret;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_stage : scoreboard bench for wb_stage                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic        mem_rd_we_i = 1'b0;
    logic [4:0]  mem_rd_addr_i = '0;
    logic        mem_is_load_i = 1'b0;
    logic [1:0]  mem_load_size_i = '0;
    logic        mem_load_unsigned_i = 1'b0;
    logic [2:0]  mem_byte_off_i = '0;
    logic [63:0] mem_alu_result_i = '0;
    logic [63:0] mem_load_data_i = '0;
    logic        hold_i = 1'b0;
    logic        rf_write_en_o;
    logic [4:0]  rf_write_addr_o;
    logic [63:0] rf_write_data_o;
    logic        misalign_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
    logic [63:0] ins0;
`endif

    typedef struct {
        logic        en;
        logic        mis;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    wb_stage #(.XLEN(64)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .mem_valid_i         (mem_valid_i),
        .mem_ready_o         (mem_ready_o),
        .mem_rd_we_i         (mem_rd_we_i),
        .mem_rd_addr_i       (mem_rd_addr_i),
        .mem_is_load_i       (mem_is_load_i),
        .mem_load_size_i     (mem_load_size_i),
        .mem_load_unsigned_i (mem_load_unsigned_i),
        .mem_byte_off_i      (mem_byte_off_i),
        .mem_alu_result_i    (mem_alu_result_i),
        .mem_load_data_i     (mem_load_data_i),
        .hold_i              (hold_i),
        .rf_write_en_o       (rf_write_en_o),
        .rf_write_addr_o     (rf_write_addr_o),
        .rf_write_data_o     (rf_write_data_o),
        .misalign_o          (misalign_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o           (instret_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [1:0] sz,
                                             input logic uns, input logic [2:0] off);
        logic [63:0] sh;
        sh = raw >> (8 * int'(off));
        case (sz)
            2'd0:    return uns ? 64'(sh[7:0])  : 64'($signed(sh[7:0]));
            2'd1:    return uns ? 64'(sh[15:0]) : 64'($signed(sh[15:0]));
            2'd2:    return uns ? 64'(sh[31:0]) : 64'($signed(sh[31:0]));
            default: return sh;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [1:0] sz, input logic [2:0] off);
        int bytes;
        bytes = 1 << sz;
        return (int'(off) % bytes) != 0;
    endfunction

    task automatic drive(input logic we, input logic [4:0] rd, input logic ld, input logic [1:0] sz,
                         input logic uns, input logic [2:0] off, input logic [63:0] alu,
                         input logic [63:0] raw);
        mem_valid_i         = 1'b1;
        mem_rd_we_i         = we;
        mem_rd_addr_i       = rd;
        mem_is_load_i       = ld;
        mem_load_size_i     = sz;
        mem_load_unsigned_i = uns;
        mem_byte_off_i      = off;
        mem_alu_result_i    = alu;
        mem_load_data_i     = raw;
    endtask

    // Offer one instruction, push its visible effect when the handshake completes.
    task automatic send(input logic we, input logic [4:0] rd, input logic ld, input logic [1:0] sz,
                        input logic uns, input logic [2:0] off, input logic [63:0] alu,
                        input logic [63:0] raw);
        exp_t e;
        logic accepted;
        int   waited;
        drive(we, rd, ld, sz, uns, off, alu, raw);
        e.mis  = ld & ref_mis(sz, off);
        e.data = ld ? ref_load(raw, sz, uns, off) : alu;
        e.rd   = rd;
        e.en   = we & (rd != 5'd0) & ~e.mis;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 50) begin
            @(negedge clk_i);
            if (mem_ready_o) begin
                accepted = 1'b1;
                if (e.en || e.mis) sb.push_back(e);
            end
            @(posedge clk_i);
            #1;
            waited++;
        end
        chk("send_accept", 64'(accepted), 64'd1);
    endtask

    task automatic idle();
        mem_valid_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && (rf_write_en_o || misalign_o)) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_en",  64'(rf_write_en_o), 64'(e.en));
                chk("sb_mis", 64'(misalign_o),    64'(e.mis));
                if (e.en) begin
                    chk("sb_addr", 64'(rf_write_addr_o), 64'(e.rd));
                    chk("sb_data", rf_write_data_o,      e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        #1 rst_ni = 1'b0;
        #10;
        chk("rst_we",    64'(rf_write_en_o),   64'd0);
        chk("rst_mis",   64'(misalign_o),      64'd0);
        chk("rst_ready", 64'(mem_ready_o),     64'd1);
        chk("rst_addr",  64'(rf_write_addr_o), 64'd0);
        chk("rst_data",  rf_write_data_o,      64'd0);
`ifdef WB_INSTRET_EN
        chk("rst_instret", instret_o, 64'd0);
`endif
        #10 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // ALU write, latency one cycle
        send(1'b1, 5'd5, 1'b0, 2'd0, 1'b0, 3'd0, 64'h1234, 64'hDEAD);
        idle();
        @(negedge clk_i);
        chk("alu_we",   64'(rf_write_en_o),   64'd1);
        chk("alu_addr", 64'(rf_write_addr_o), 64'd5);
        chk("alu_data", rf_write_data_o,      64'h1234);
        @(posedge clk_i); #1;

        // Byte load at offset 3, signed then unsigned
        send(1'b1, 5'd3, 1'b1, 2'd0, 1'b0, 3'd3, 64'd0, 64'h0000_0000_8000_0000);
        idle();
        @(negedge clk_i);
        chk("lb_signed", rf_write_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        @(posedge clk_i); #1;
        send(1'b1, 5'd3, 1'b1, 2'd0, 1'b1, 3'd3, 64'd0, 64'h0000_0000_8000_0000);
        idle();
        @(negedge clk_i);
        chk("lb_unsigned", rf_write_data_o, 64'h80);
        @(posedge clk_i); #1;

        // Misaligned half load pulses misalign_o once, no write
        send(1'b1, 5'd9, 1'b1, 2'd1, 1'b0, 3'd1, 64'd0, 64'h1122_3344_5566_7788);
        idle();
        pulses = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (misalign_o) pulses++;
            chk("mis_no_we", 64'(rf_write_en_o), 64'd0);
        end
        chk("mis_pulses", 64'(pulses), 64'd1);
        @(posedge clk_i); #1;

        // Hold for three cycles with another instruction waiting
        send(1'b1, 5'd7, 1'b0, 2'd0, 1'b0, 3'd0, 64'hAAAA_0000_BBBB_0007, 64'd0);
`ifdef WB_INSTRET_EN
        ins0 = instret_o;
`endif
        drive(1'b1, 5'd8, 1'b0, 2'd0, 1'b0, 3'd0, 64'h8888, 64'd0);
        hold_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("hold_ready", 64'(mem_ready_o),   64'd0);
            chk("hold_we",    64'(rf_write_en_o), 64'd0);
            @(posedge clk_i); #1;
        end
        hold_i = 1'b0;
        send(1'b1, 5'd8, 1'b0, 2'd0, 1'b0, 3'd0, 64'h8888, 64'd0);
        idle();
`ifdef WB_INSTRET_EN
        chk("hold_instret", instret_o, ins0 + 64'd1);
`endif
        @(posedge clk_i); #1;

        // Write to x0 is suppressed but still retires
        send(1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h5555, 64'd0);
        idle();
`ifdef WB_INSTRET_EN
        ins0 = instret_o;
`endif
        @(negedge clk_i);
        chk("x0_we", 64'(rf_write_en_o), 64'd0);
        @(posedge clk_i); #1;
`ifdef WB_INSTRET_EN
        chk("x0_instret", instret_o, ins0 + 64'd1);
`endif

        // Back-to-back random mix of ALU ops and loads
        for (int i = 0; i < 24; i++) begin
            send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end
        idle();
        repeat (3) @(posedge clk_i);
        #1;

        // Reset while FULL discards the held entry
        send(1'b1, 5'd12, 1'b0, 2'd0, 1'b0, 3'd0, 64'hCAFE_F00D, 64'd0);
        idle();
        hold_i = 1'b1;
        @(negedge clk_i);
        chk("pre_rst_ready", 64'(mem_ready_o), 64'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_we",    64'(rf_write_en_o),   64'd0);
        chk("mid_rst_addr",  64'(rf_write_addr_o), 64'd0);
        chk("mid_rst_data",  rf_write_data_o,      64'd0);
        chk("mid_rst_ready", 64'(mem_ready_o),     64'd1);
        sb.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        hold_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("post_rst_we", 64'(rf_write_en_o), 64'd0);
        end

        @(posedge clk_i); #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 mem_valid_i  input  1  MEM stage presents an instruction.
REQ-005 mem_ready_o  output  1  WB accepts the presented instruction this cycle.
REQ-006 mem_rd_we_i  input  1  instruction writes rd.
REQ-007 mem_rd_addr_i  input  5  destination register index.
REQ-008 mem_is_load_i  input  1  result comes from load data, else from ALU result.
REQ-009 mem_load_size_i  input  2  0 byte, 1 half, 2 word, 3 dword.
REQ-010 mem_load_unsigned_i  input  1  zero-extend when 1, sign-extend when 0.
REQ-011 mem_byte_off_i  input  3  byte offset of the load address within the doubleword.
REQ-012 mem_alu_result_i  input  64  ALU result.
REQ-013 mem_load_data_i  input  64  raw aligned doubleword from data memory.
REQ-014 hold_i  input  1  hazard-unit stall; WB must not retire while high.
REQ-015 rf_write_en_o  output  1  register-file write enable.
REQ-016 rf_write_addr_o  output  5  register-file write index.
REQ-017 rf_write_data_o  output  64  register-file write data.
REQ-018 misalign_o  output  1  one-cycle pulse: retiring load was misaligned.
REQ-019 instret_o  output  64  retired-instruction count (present only with WB_INSTRET_EN).

Function
REQ-020 Stage SHALL hold one entry (wb_valid plus captured rd, we, data, misalign flag); states EMPTY and FULL.
REQ-021 mem_ready_o SHALL equal !wb_valid | !hold_i.
REQ-022 Accept = mem_valid_i & mem_ready_o; accepted entry SHALL appear on outputs the next cycle (latency 1).
REQ-023 Retire = wb_valid & !hold_i; on a retire cycle without accept the stage SHALL go EMPTY; retire and accept in the same cycle SHALL replace the entry (back-to-back throughput 1/cycle).
REQ-024 While hold_i=1 and FULL, the entry SHALL be held unchanged and rf_write_en_o SHALL be 0.
REQ-025 rf_write_en_o SHALL be wb_valid & we & !hold_i & !misalign & (rd != 0); writes to x0 are suppressed.
REQ-026 Load data SHALL be shifted right by 8*byte_off, truncated to size, then sign/zero-extended to 64 bits before capture; dword ignores mem_load_unsigned_i.
REQ-027 Misaligned = load & ((half & off[0]) | (word & off[1:0]!=0) | (dword & off!=0)); SHALL be computed at capture.
REQ-028 misalign_o SHALL be 1 exactly on the retire cycle of a misaligned entry; no register write occurs.
REQ-029 Non-load instructions SHALL ignore size, unsigned and offset inputs; the misalign flag is 0.
REQ-030 rf_write_addr_o/rf_write_data_o SHALL be driven from the entry register regardless of wb_valid.

Reset
REQ-031 On rst_ni low, immediately: wb_valid=0, rd=0, data=0, misalign=0, instret=0; hence rf_write_en_o=0, misalign_o=0, mem_ready_o=1.
REQ-032 Reset asserted mid-operation SHALL discard the held entry with no write.

Configuration
REQ-033 Macro WB_INSTRET_EN: when defined, instret_o SHALL increment by 1 on every retire cycle (misaligned loads included), wrapping at 2^64; when undefined, the counter and instret_o port SHALL be absent.

Structure
REQ-034 Load-size encodings and XLEN constant SHALL live in the shared package aurora_pkg.
REQ-035 Load extraction/extension SHALL be a combinational sub-module load_align.

Verification
REQ-036 ALU op rd=5, data 0x1234 accepted cycle N -> rf_write_en_o=1, addr 5, data 0x1234 at cycle N+1.
REQ-037 Load byte off=3, signed, raw 0x00000000_80000000 -> rf_write_data_o 0xFFFFFFFF_FFFFFF80; unsigned -> 0x80.
REQ-038 Load half off=1 -> misalign_o pulses once, rf_write_en_o stays 0.
REQ-039 Entry held 3 cycles by hold_i=1 -> mem_ready_o=0, no write; hold_i drops -> one write, instret +1.
REQ-040 Write to rd=0 -> rf_write_en_o=0, instret still +1.
REQ-041 rst_ni low while FULL -> outputs zero immediately, no write after release.
